// File: rtl/line_clear_sequencer.sv
// line_clear_sequencer
// Multi-cycle row-clear controller for the playfield. After a piece locks,
// game control pulses start with the merged board. The board is scanned
// bottom-up. Each full row is removed in one SHIFT cycle, which moves the
// rows above it down by one. The compacted board, the number of rows removed
// and a saturating running score are then published together with a one-cycle
// done pulse.
//
// Optional feature: define LINE_CLEAR_BONUS_EN to score multi-row clears with
// a bonus table. Otherwise each cleared row is worth one point.
//
// Ports:
//   clk           in   system clock, rising edge
//   rst           in   asynchronous active-low reset
//   clr           in   synchronous new-game clear (priority over start)
//   start         in   one-cycle request, captures board_in
//   board_in      in   COLS*ROWS board; row r at [r*COLS +: COLS], row 0 on top
//   busy          out  high while an operation is in progress
//   done          out  one-cycle completion pulse
//   board_out     out  compacted board, same layout as board_in
//   lines_cleared out  rows removed by the last operation
//   score         out  accumulated score, saturates at SCORE_MAX
module line_clear_sequencer #(
  parameter int COLS      = 10,
  parameter int ROWS      = 20,
  parameter int SCORE_W   = 7,
  parameter int SCORE_MAX = 99
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clr,
  input  logic                         start,
  input  logic [COLS*ROWS-1:0]         board_in,
  output logic                         busy,
  output logic                         done,
  output logic [COLS*ROWS-1:0]         board_out,
  output logic [$clog2(ROWS+1)-1:0]    lines_cleared,
  output logic [SCORE_W-1:0]           score
);

  localparam int BW    = COLS * ROWS;
  localparam int LC_W  = $clog2(ROWS + 1);
  localparam int PTR_W = $clog2(ROWS);
  localparam int SUM_W = SCORE_W + 4;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t            state;
  logic [BW-1:0]     wb;
  logic [PTR_W-1:0]  ptr;
  logic [LC_W-1:0]   n;

  // Rows 1..p take rows 0..p-1, and row 0 becomes empty.
  function automatic logic [BW-1:0] shift_down(input logic [BW-1:0] b,
                                               input logic [PTR_W-1:0] p);
    logic [BW-1:0] o;
    o = b;
    o[COLS-1:0] = '0;
    for (int r = 1; r < ROWS; r++) begin
      if (r <= int'(p)) o[r*COLS +: COLS] = b[(r-1)*COLS +: COLS];
    end
    return o;
  endfunction

  function automatic logic [SUM_W-1:0] pts(input logic [LC_W-1:0] k);
    int kk;
    kk = int'(k);
`ifdef LINE_CLEAR_BONUS_EN
    case (kk)
      0:       return SUM_W'(0);
      1:       return SUM_W'(1);
      2:       return SUM_W'(3);
      3:       return SUM_W'(5);
      4:       return SUM_W'(8);
      default: return SUM_W'(2 * kk);
    endcase
`else
    return SUM_W'(kk);
`endif
  endfunction

  function automatic logic [SCORE_W-1:0] sat_score(input logic [SUM_W-1:0] s);
    return (s > SUM_W'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : s[SCORE_W-1:0];
  endfunction

  logic              row_full;
  logic              at_floor;
  logic [BW-1:0]     wb_shift;
  logic [LC_W-1:0]   n_inc;

  assign row_full = &wb[int'(ptr)*COLS +: COLS];
  assign wb_shift = shift_down(wb, ptr);
  assign n_inc    = n + LC_W'(1);
  // After n shifts, rows 0..n-1 of wb are guaranteed empty. Once ptr has come
  // down to n, nothing is left that could be full, so the scan ends there.
  // With no clears this reduces to stopping at ptr==0. The operation always
  // takes ROWS+N cycles.
  assign at_floor = (LC_W'(ptr) <= n);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      wb            <= '0;
      ptr           <= '0;
      n             <= '0;
      board_out     <= '0;
      lines_cleared <= '0;
      score         <= '0;
    end else if (clr) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      wb            <= '0;
      ptr           <= '0;
      n             <= '0;
      board_out     <= '0;
      lines_cleared <= '0;
      score         <= '0;
    end else begin
      case (state)
        // DONE also accepts start. The edge that leaves DONE can therefore
        // begin the next operation, so start-to-start spacing is ROWS+N+1.
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            wb    <= board_in;
            ptr   <= PTR_W'(ROWS - 1);
            n     <= '0;
            busy  <= 1'b1;
            state <= SCAN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        SCAN: begin
          if (row_full) begin
            state <= SHIFT;
          end else if (at_floor) begin
            board_out     <= wb;
            lines_cleared <= n;
            score         <= sat_score(SUM_W'(score) + pts(n));
            done          <= 1'b1;
            state         <= DONE;
          end else begin
            ptr <= ptr - PTR_W'(1);
          end
        end
        SHIFT: begin
          wb <= wb_shift;
          n  <= n_inc;
          if (at_floor) begin
            board_out     <= wb_shift;
            lines_cleared <= n_inc;
            score         <= sat_score(SUM_W'(score) + pts(n_inc));
            done          <= 1'b1;
            state         <= DONE;
          end else begin
            state <= SCAN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_line_clear_sequencer.sv
// Testbench for line_clear_sequencer at its default parameters.
// Each expected result is queued when start is issued and compared when done
// arrives. The expected values come from an independent compaction and score
// model.
module tb_line_clear_sequencer;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int BW   = COLS * ROWS;
  localparam int SMAX = 99;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic [BW-1:0] board_in = '0;
  logic          busy;
  logic          done;
  logic [BW-1:0] board_out;
  logic [4:0]    lines_cleared;
  logic [6:0]    score;

  line_clear_sequencer dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .start         (start),
    .board_in      (board_in),
    .busy          (busy),
    .done          (done),
    .board_out     (board_out),
    .lines_cleared (lines_cleared),
    .score         (score)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [BW-1:0] board;
    int            lines;
    int            score;
    int            lat;
    int            e0;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   model_score = 0;

  function automatic int model_pts(input int k);
`ifdef LINE_CLEAR_BONUS_EN
    case (k)
      0: return 0;
      1: return 1;
      2: return 3;
      3: return 5;
      4: return 8;
      default: return 2 * k;
    endcase
`else
    return k;
`endif
  endfunction

  // Keep the non-full rows in bottom-up order and stack them at the bottom.
  function automatic void model_compact(input logic [BW-1:0] b,
                                        output logic [BW-1:0] o, output int k);
    int dst;
    logic [COLS-1:0] row;
    o = '0;
    k = 0;
    dst = ROWS - 1;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = b[r*COLS +: COLS];
      if (row == 10'h3FF) k++;
      else begin
        o[dst*COLS +: COLS] = row;
        dst--;
      end
    end
  endfunction

  // Called at a negedge. Returns at the negedge that follows the edge which
  // samples start.
  task automatic issue(input logic [BW-1:0] b);
    exp_t e;
    logic [BW-1:0] ob;
    int k;
    board_in = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    model_compact(b, ob, k);
    model_score = model_score + model_pts(k);
    if (model_score > SMAX) model_score = SMAX;
    e.board = ob;
    e.lines = k;
    e.score = model_score;
    e.lat   = ROWS + k;
    e.e0    = cyc;
    q.push_back(e);
  endtask

  // Returns at the negedge where done is first seen high.
  task automatic wait_done(input string name);
    exp_t e;
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s done_timeout: done not seen within 100 cycles", name);
    end else if (q.size() == 0) begin
      n_fail++;
      $display("FAIL %s unexpected_done: done with no operation pending", name);
    end else begin
      e = q.pop_front();
      if (cyc - e.e0 !== e.lat) begin
        n_fail++;
        $display("FAIL %s latency: got %0d expected %0d", name, cyc - e.e0, e.lat);
      end
      n_chk++;
      if (board_out !== e.board) begin
        n_fail++;
        $display("FAIL %s board_out: got %h expected %h", name, board_out, e.board);
      end
      n_chk++;
      if (int'(lines_cleared) !== e.lines) begin
        n_fail++;
        $display("FAIL %s lines_cleared: got %0d expected %0d", name, lines_cleared, e.lines);
      end
      n_chk++;
      if (int'(score) !== e.score) begin
        n_fail++;
        $display("FAIL %s score: got %0d expected %0d", name, score, e.score);
      end
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
    end
  endtask

  task automatic check_zero(input string name);
    n_chk++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ctrl_zero: got busy=%b done=%b expected 0 0", name, busy, done);
    end
    n_chk++;
    if (board_out !== '0 || lines_cleared !== 5'd0 || score !== 7'd0) begin
      n_fail++;
      $display("FAIL %s data_zero: got lines=%0d score=%0d board=%h expected 0", name,
               lines_cleared, score, board_out);
    end
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("reset_held");
    rst = 1'b1;
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy !== 1'b0 || done !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL reset_idle: got busy/done activity expected none");
    end
    check_zero("reset_idle_end");
  endtask

  task automatic test_no_full();
    logic [BW-1:0] b;
    b = '0;
    b[19*COLS +: COLS] = 10'h3FE;
    issue(b);
    wait_done("no_full");
    check_idle("no_full");
  endtask

  task automatic test_single();
    logic [BW-1:0] b;
    b = '0;
    b[19*COLS +: COLS] = 10'h3FF;
    b[18*COLS +: COLS] = 10'h001;
    b[17*COLS +: COLS] = 10'h201;
    issue(b);
    wait_done("single");
    n_chk++;
    if (board_out[19*COLS +: COLS] !== 10'h001 || board_out[18*COLS +: COLS] !== 10'h201) begin
      n_fail++;
      $display("FAIL single rows: got r19=%h r18=%h expected 001 201",
               board_out[19*COLS +: COLS], board_out[18*COLS +: COLS]);
    end
    check_idle("single");
  endtask

  task automatic test_nonadjacent();
    logic [BW-1:0] b;
    b = '0;
    b[19*COLS +: COLS] = 10'h3FF;
    b[18*COLS +: COLS] = 10'h0F0;
    b[17*COLS +: COLS] = 10'h3FF;
    b[16*COLS +: COLS] = 10'h00F;
    issue(b);
    wait_done("nonadjacent");
    check_idle("nonadjacent");
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    a = '0;
    a[19*COLS +: COLS] = 10'h3FF;
    a[18*COLS +: COLS] = 10'h155;
    b = '0;
    b[10*COLS +: COLS] = 10'h2AA;
    issue(a);
    wait_done("b2b_first");
    issue(b);
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_accept: got busy=%b done=%b expected 1 0", busy, done);
    end
    wait_done("b2b_second");
    check_idle("b2b_second");
  endtask

  task automatic test_saturation();
    logic [BW-1:0] b;
    int rem;
    int k;
    for (int it = 0; it < 30 && model_score < 97; it++) begin
      rem = 97 - model_score;
      k = 0;
      for (int j = ROWS; j >= 0; j--) begin
        if (model_pts(j) <= rem) begin
          k = j;
          break;
        end
      end
      b = '0;
      for (int r = 0; r < k; r++) b[(ROWS-1-r)*COLS +: COLS] = 10'h3FF;
      b[0 +: COLS] = 10'h010;
      issue(b);
      wait_done("preload");
      check_idle("preload");
    end
    n_chk++;
    if (int'(score) !== 97) begin
      n_fail++;
      $display("FAIL preload_score: got %0d expected 97", score);
    end
    b = '1;
    issue(b);
    wait_done("full_board");
    n_chk++;
    if (int'(score) !== 99 || int'(lines_cleared) !== 20 || board_out !== '0) begin
      n_fail++;
      $display("FAIL full_board_sat: got score=%0d lines=%0d expected 99 20", score, lines_cleared);
    end
    check_idle("full_board");
  endtask

  task automatic test_abort_ignore();
    logic [BW-1:0] b;
    bit seen;
    b = '0;
    b[19*COLS +: COLS] = 10'h3FF;
    b[18*COLS +: COLS] = 10'h3FF;
    b[17*COLS +: COLS] = 10'h0AA;
    issue(b);
    repeat (4) @(negedge clk);
    board_in = '1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    board_in = {BW/8{8'h5A}};
    wait_done("ignore");
    check_idle("ignore");
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (busy !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL ignore_queued: got busy after done expected idle");
    end
    b = '0;
    b[19*COLS +: COLS] = 10'h3FF;
    b[15*COLS +: COLS] = 10'h123;
    issue(b);
    repeat (7) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check_zero("clr_abort");
    q.delete();
    model_score = 0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    n_chk++;
    if (seen) begin
      n_fail++;
      $display("FAIL clr_no_done: got done/busy after abort expected none");
    end
  endtask

  task automatic test_rst_mid_shift();
    logic [BW-1:0] b;
    b = '0;
    b[19*COLS +: COLS] = 10'h3FF;
    b[5*COLS +: COLS]  = 10'h003;
    issue(b);
    wait_done("pre_rst");
    check_idle("pre_rst");
    issue(b);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("rst_async");
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    model_score = 0;
    issue(b);
    wait_done("post_rst");
    check_idle("post_rst");
  endtask

  initial begin
    test_reset();
    test_no_full();
    test_single();
    test_nonadjacent();
    test_back_to_back();
    test_saturation();
    test_abort_ignore();
    test_rst_mid_shift();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
